// File: rtl/nios_ii_system_sysid_pkg.sv
// Shared state encoding, bus addresses and default expected values for the
// Nios II system-ID checker.
package nios_ii_system_sysid_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ID   = 3'd1,
    WAIT_ID = 3'd2,
    RD_TS   = 3'd3,
    WAIT_TS = 3'd4,
    CHECK   = 3'd5,
    FAIL    = 3'd6
  } sysid_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_ID        = 32'd0;
  localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd1429999420;
  localparam int unsigned SYSID_DEFAULT_TIMEOUT   = 255;
  localparam int unsigned SYSID_DEFAULT_RETRIES   = 3;
  localparam int unsigned SYSID_DEFAULT_REFRESH   = 1000000;

  localparam int unsigned SYSID_TIMEOUT_WIDTH = 16;
  localparam int unsigned SYSID_REFRESH_WIDTH = 32;

  // Address phase: read strobe is driven and waitrequest applies.
  function automatic logic sysid_is_read(input sysid_state_t s);
    return (s == RD_ID) || (s == RD_TS);
  endfunction

  // Data phase: read accepted, waiting for readdatavalid.
  function automatic logic sysid_is_wait(input sysid_state_t s);
    return (s == WAIT_ID) || (s == WAIT_TS);
  endfunction

endpackage

// File: rtl/nios_ii_system_sysid_read_timer.sv
// Loadable down-counter; expire flags the last enabled cycle of a loaded
// interval. Used for the per-read timeout and the periodic refresh interval.
module nios_ii_system_sysid_read_timer
  import nios_ii_system_sysid_pkg::*;
#(
  parameter int unsigned WIDTH = SYSID_TIMEOUT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  // A loaded value N expires during the N-th enabled cycle after the load.
  assign expire = enable && (count == WIDTH'(1));

endmodule

// File: rtl/nios_ii_system_sysid_checker.sv
// Avalon-MM master that reads sysid words 0/1 and compares them with build-time
// values. Optional periodic re-check: define SYSID_CHECK_PERIODIC_EN.
module nios_ii_system_sysid_checker
  import nios_ii_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
  parameter int unsigned TIMEOUT_CYCLES     = SYSID_DEFAULT_TIMEOUT,
  parameter int unsigned MAX_RETRIES        = SYSID_DEFAULT_RETRIES,
  parameter int unsigned REFRESH_CYCLES     = SYSID_DEFAULT_REFRESH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        system_ok,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  localparam int unsigned RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [SYSID_TIMEOUT_WIDTH-1:0] TMO_LOAD = SYSID_TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

  sysid_state_t       state;
  sysid_state_t       next_state;
  logic [RETRY_W-1:0] retry_count;
  logic               can_retry;
  logic               read_returned;
  logic               tmo_load;
  logic               tmo_enable;
  logic               tmo_expire;
  logic               cap_id;
  logic               cap_ts;
  logic               do_retry;
  logic               auto_start;
  logic               begin_check;
  logic               check_ending;

  assign avm_read     = sysid_is_read(state);
  assign avm_address  = (state == RD_TS) || (state == WAIT_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign busy         = (state != IDLE);
  assign tmo_enable   = sysid_is_read(state) || sysid_is_wait(state);
  assign can_retry    = (retry_count < RETRY_W'(MAX_RETRIES));
  assign begin_check  = (state == IDLE) && (start || auto_start);
  assign check_ending = (state == CHECK) || (state == FAIL);

  // Data counts only for an outstanding read: in the address phase it must
  // coincide with acceptance (zero-latency slave), otherwise it is stray.
  assign read_returned = avm_readdatavalid &&
                         (sysid_is_wait(state) || (sysid_is_read(state) && !avm_waitrequest));

  nios_ii_system_sysid_read_timer #(
    .WIDTH(SYSID_TIMEOUT_WIDTH)
  ) u_timeout_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmo_load),
    .enable     (tmo_enable),
    .load_value (TMO_LOAD),
    .expire     (tmo_expire)
  );

`ifdef SYSID_CHECK_PERIODIC_EN
  logic refresh_armed;
  logic refresh_expire;

  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_armed <= 1'b0;
    end else if (check_ending) begin
      refresh_armed <= 1'b1;
    end
  end

  nios_ii_system_sysid_read_timer #(
    .WIDTH(SYSID_REFRESH_WIDTH)
  ) u_refresh_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (check_ending),
    .enable     (refresh_armed && (state == IDLE)),
    .load_value (SYSID_REFRESH_WIDTH'(REFRESH_CYCLES)),
    .expire     (refresh_expire)
  );

  assign auto_start = refresh_expire;
`else
  assign auto_start = 1'b0;
`endif

  // Returned data beats a simultaneous timeout; a timeout beats acceptance.
  always_comb begin
    next_state = state;
    tmo_load   = 1'b0;
    cap_id     = 1'b0;
    cap_ts     = 1'b0;
    do_retry   = 1'b0;
    case (state)
      IDLE: begin
        if (start || auto_start) begin
          next_state = RD_ID;
          tmo_load   = 1'b1;
        end
      end
      RD_ID, WAIT_ID: begin
        if (read_returned) begin
          cap_id     = 1'b1;
          next_state = RD_TS;
          tmo_load   = 1'b1;
        end else if (tmo_expire) begin
          if (can_retry) begin
            do_retry   = 1'b1;
            next_state = RD_ID;
            tmo_load   = 1'b1;
          end else begin
            next_state = FAIL;
          end
        end else if ((state == RD_ID) && !avm_waitrequest) begin
          next_state = WAIT_ID;
        end
      end
      RD_TS, WAIT_TS: begin
        if (read_returned) begin
          cap_ts     = 1'b1;
          next_state = CHECK;
        end else if (tmo_expire) begin
          if (can_retry) begin
            do_retry   = 1'b1;
            next_state = RD_ID;
            tmo_load   = 1'b1;
          end else begin
            next_state = FAIL;
          end
        end else if ((state == RD_TS) && !avm_waitrequest) begin
          next_state = WAIT_TS;
        end
      end
      CHECK:   next_state = IDLE;
      FAIL:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      retry_count <= '0;
    end else begin
      state <= next_state;
      if (begin_check) begin
        retry_count <= '0;
      end else if (do_retry) begin
        retry_count <= retry_count + RETRY_W'(1);
      end
    end
  end

  // A self-started re-check leaves system_ok alone until its own verdict.
  always_ff @(posedge clock) begin
    if (reset) begin
      done        <= 1'b0;
      id_match    <= 1'b0;
      ts_match    <= 1'b0;
      system_ok   <= 1'b0;
      timeout     <= 1'b0;
      captured_id <= '0;
      captured_ts <= '0;
    end else begin
      done <= check_ending;
      if (begin_check) begin
        id_match <= 1'b0;
        ts_match <= 1'b0;
        timeout  <= 1'b0;
        if (start) begin
          system_ok <= 1'b0;
        end
      end
      if (cap_id) begin
        captured_id <= avm_readdata;
      end
      if (cap_ts) begin
        captured_ts <= avm_readdata;
      end
      if (state == CHECK) begin
        id_match  <= (captured_id == EXPECTED_ID);
        ts_match  <= (captured_ts == EXPECTED_TIMESTAMP);
        system_ok <= (captured_id == EXPECTED_ID) && (captured_ts == EXPECTED_TIMESTAMP);
      end
      if (state == FAIL) begin
        timeout   <= 1'b1;
        system_ok <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nios_ii_system_sysid_checker.sv
// Directed bench for the sysid checker: a behavioural sysid slave plus a
// scoreboard of expected check results popped on each done pulse.
module tb_nios_ii_system_sysid_checker;

  localparam logic [31:0] EXP_ID  = 32'd0;
  localparam logic [31:0] EXP_TS  = 32'd1429999420;
  localparam int          TMO     = 8;
  localparam int          RETRIES = 2;

  logic        clock;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy;
  logic        done;
  logic        id_match;
  logic        ts_match;
  logic        system_ok;
  logic        timeout;
  logic [31:0] captured_id;
  logic [31:0] captured_ts;

  nios_ii_system_sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (TMO),
    .MAX_RETRIES        (RETRIES),
    .REFRESH_CYCLES     (20)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .id_match          (id_match),
    .ts_match          (ts_match),
    .system_ok         (system_ok),
    .timeout           (timeout),
    .captured_id       (captured_id),
    .captured_ts       (captured_ts)
  );

  typedef struct {
    logic [31:0] cid;
    logic [31:0] cts;
    logic        idm;
    logic        tsm;
    logic        ok;
    logic        tmo;
    int          lat;
    int          start_cyc;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  exp_t        sb[$];
  resp_t       pend[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          accepts = 0;
  int          stall_id = 0, lat_id = 0, stall_ts = 0, lat_ts = 0;
  int          stall_left = 0;
  bit          in_read = 0;
  bit          respond = 1;
  logic [31:0] id_val = EXP_ID;
  logic [31:0] ts_val = EXP_TS;
  logic [31:0] last_cid = '0;
  logic [31:0] last_cts = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Sysid slave: per-address stall and read latency, driven on the falling edge.
  always @(negedge clock) begin : slave
    resp_t r;
    avm_readdatavalid = 1'b0;
    avm_waitrequest   = 1'b0;
    if (avm_read === 1'b1) begin
      if (!in_read) begin
        in_read    = 1'b1;
        stall_left = avm_address ? stall_ts : stall_id;
      end
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        in_read = 1'b0;
        accepts++;
        if (respond) begin
          r.due  = cyc + (avm_address ? lat_ts : lat_id);
          r.data = avm_address ? ts_val : id_val;
          pend.push_back(r);
        end
      end
    end else begin
      in_read = 1'b0;
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = pend[0].data;
      void'(pend.pop_front());
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Configures the slave, pulses start on the current falling edge and records
  // the expected outcome. Returns one cycle after start was sampled.
  task automatic applyStimulus(input logic [31:0] idv, input logic [31:0] tsv,
                               input int si, input int li, input int st, input int lt,
                               input bit resp);
    exp_t e;
    id_val   = idv;
    ts_val   = tsv;
    stall_id = si;
    lat_id   = li;
    stall_ts = st;
    lat_ts   = lt;
    respond  = resp;
    if (resp) begin
      e.cid = idv;
      e.cts = tsv;
      e.idm = (idv == EXP_ID);
      e.tsm = (tsv == EXP_TS);
      e.ok  = (idv == EXP_ID) && (tsv == EXP_TS);
      e.tmo = 1'b0;
      e.lat = 2 + (si + 1 + li) + (st + 1 + lt);
    end else begin
      e.cid = last_cid;
      e.cts = last_cts;
      e.idm = 1'b0;
      e.tsm = 1'b0;
      e.ok  = 1'b0;
      e.tmo = 1'b1;
      e.lat = 2 + (RETRIES + 1) * TMO;
    end
    last_cid    = e.cid;
    last_cts    = e.cts;
    e.start_cyc = cyc;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic collectResult(input string tag, input int budget);
    bit   found = 0;
    exp_t e;
    for (int n = 0; n < budget; n++) begin
      if (done === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge clock);
    end
    checkOutput({tag, ".done_seen"}, 32'(found), 32'd1);
    if (sb.size() == 0) begin
      checkOutput({tag, ".sb_entry"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    if (found) begin
      checkOutput({tag, ".latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
      checkOutput({tag, ".id_match"}, 32'(id_match), 32'(e.idm));
      checkOutput({tag, ".ts_match"}, 32'(ts_match), 32'(e.tsm));
      checkOutput({tag, ".system_ok"}, 32'(system_ok), 32'(e.ok));
      checkOutput({tag, ".timeout"}, 32'(timeout), 32'(e.tmo));
      checkOutput({tag, ".captured_id"}, captured_id, e.cid);
      checkOutput({tag, ".captured_ts"}, captured_ts, e.cts);
    end
  endtask

  initial begin
    start        = 1'b0;
    reset        = 1'b1;
    avm_readdata = '0;
    repeat (3) @(negedge clock);

    $display("[TB] reset values");
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.done", 32'(done), 32'd0);
    checkOutput("rst.avm_read", 32'(avm_read), 32'd0);
    checkOutput("rst.system_ok", 32'(system_ok), 32'd0);
    checkOutput("rst.timeout", 32'(timeout), 32'd0);
    checkOutput("rst.captured_ts", captured_ts, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] zero-wait slave, then start on the done cycle");
    applyStimulus(EXP_ID, EXP_TS, 0, 0, 0, 0, 1);
    checkOutput("basic.busy_rise", 32'(busy), 32'd1);
    collectResult("basic", 40);
    applyStimulus(EXP_ID, EXP_TS, 0, 0, 0, 0, 1);
    checkOutput("b2b.busy", 32'(busy), 32'd1);
    checkOutput("b2b.ok_cleared", 32'(system_ok), 32'd0);
    collectResult("b2b", 40);
    @(negedge clock);

    $display("[TB] stalled slave with start while busy");
    applyStimulus(EXP_ID, EXP_TS, 3, 2, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("stall.avm_read%0d", i), 32'(avm_read), 32'd1);
      checkOutput($sformatf("stall.avm_addr%0d", i), 32'(avm_address), 32'd0);
      @(negedge clock);
    end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    collectResult("stall", 40);
    repeat (2) @(negedge clock);
    checkOutput("stall.no_restart", 32'(busy), 32'd0);

    $display("[TB] timestamp off by one");
    applyStimulus(EXP_ID, EXP_TS + 32'd1, 0, 0, 0, 0, 1);
    collectResult("ts_bad", 40);
    @(negedge clock);

    $display("[TB] silent slave exhausts retries");
    accepts = 0;
    applyStimulus(EXP_ID, EXP_TS, 0, 0, 0, 0, 0);
    collectResult("tmo", 80);
    checkOutput("tmo.attempts", 32'(accepts), 32'(RETRIES + 1));
    @(negedge clock);
    applyStimulus(EXP_ID, EXP_TS, 0, 0, 0, 0, 1);
    checkOutput("tmo.cleared", 32'(timeout), 32'd0);
    collectResult("after_tmo", 40);
    @(negedge clock);

    $display("[TB] data on the timeout threshold cycle");
    accepts = 0;
    applyStimulus(EXP_ID, EXP_TS, 0, TMO - 1, 0, 0, 1);
    collectResult("tie", 40);
    checkOutput("tie.reads", 32'(accepts), 32'd2);
    @(negedge clock);

    $display("[TB] reset while waiting for the timestamp");
    applyStimulus(32'h1234_5678, EXP_TS, 0, 0, 0, 5, 1);
    repeat (2) @(negedge clock);
    checkOutput("rstmid.in_wait", 32'({busy, avm_read}), 32'b10);
    checkOutput("rstmid.cid_pre", captured_id, 32'h1234_5678);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("rstmid.avm_read", 32'(avm_read), 32'd0);
    checkOutput("rstmid.busy", 32'(busy), 32'd0);
    checkOutput("rstmid.captured_id", captured_id, 32'd0);
    sb.delete();
    last_cid = '0;
    last_cts = '0;
    repeat (6) @(negedge clock);
    checkOutput("rstmid.late_ignored", captured_ts, 32'd0);
    checkOutput("rstmid.idle", 32'(busy), 32'd0);
    applyStimulus(EXP_ID, EXP_TS, 0, 0, 0, 0, 1);
    collectResult("post_rst", 40);

    checkOutput("sb.empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
